mdu_sequencer: RTL and testbench
================================

// Module: mdu_sequencer
// PURPOSE
//  Iterative MULT/MULTU/DIV/DIVU sequencer for the Execute stage; one radix-2 step per cycle.
//  Borrows the shared 32-bit ALU for every add/sub step, steering it through alu_sel/alu_a/alu_b/alu_control.
//  Owns the architectural HI/LO registers; raises busy so hazard logic stalls on MFHI/MFLO and new mult/div ops.
// PARAMETERS
//  WIDTH       32  operand width; must match the ALU (only 32 supported)
//  DONE_PULSE  1   1: done is a 1-cycle pulse; 0: done held until next accepted start or flush
// PORTS
//  clk          in   1   rising-edge clock
//  rst_n        in   1   asynchronous active-low reset
//  start        in   1   launch op; sampled only in IDLE
//  op           in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  rs_val       in   32  multiplicand / dividend
//  rt_val       in   32  multiplier / divisor
//  flush        in   1   abort in-flight op
//  busy         out  1   op in flight (RUN or FIX)
//  done         out  1   hi/lo just updated
//  div_by_zero  out  1   last completed op was DIV/DIVU with rt_val==0; updated with done
//  hi, lo       out  32  architectural HI/LO; written only in FIX
//  alu_sel      out  1   1: ALU inputs taken from this block (RUN only)
//  alu_a, alu_b out  32  ALU operands
//  alu_control  out  3   ALU op: 010 ADD, 110 SUB
//  alu_result   in   32  ALU result (combinational return)
// BEHAVIOUR
//  Reset: state IDLE; busy=done=div_by_zero=alu_sel=0; hi=lo=0; alu_a=alu_b=0; alu_control=010.
//  States: IDLE -start-> RUN (FIX directly if DIV/DIVU and rt_val==0); RUN -32 steps-> FIX; FIX -> IDLE.
//  Launch: latch |rs|,|rt| (abs only for signed ops), sign flags, cnt=0; start while busy ignored, no queue.
//  Timing: start high in cycle 0 -> busy cycles 1..33 (RUN 1..32, FIX 33) -> done=1 in cycle 34.
//   Div-by-zero: FIX in cycle 1, done in cycle 2. A new start is accepted in the done cycle.
//  Working regs acc_hi/acc_lo are internal; hi/lo never show partial results.
//  MUL step: alu_a=acc_hi, alu_b=acc_lo[0]?mcand:0, ADD; carry=(alu_result<alu_a) unsigned;
//   {acc_hi,acc_lo} <= {carry,alu_result,acc_lo[31:1]}. Init acc_hi=0, acc_lo=|multiplier|.
//  DIV step (restoring): sh={acc_hi[30:0],acc_lo[31]}; alu_a=sh, alu_b=divisor, SUB;
//   take = acc_hi[31] | !(sh<divisor); acc_hi<=take?alu_result:sh; acc_lo<={acc_lo[30:0],take}.
//   Init acc_hi=0, acc_lo=|dividend|.
//  FIX: MULT negates 64-bit product if signs differ; DIV negates quotient if signs differ,
//   remainder takes the dividend's sign; negation internal, not via ALU. Writes hi/lo, sets done.
//  Div-by-zero: hi=rs_val, lo=32'hFFFF_FFFF, div_by_zero=1. DIV 0x8000_0000/-1: lo=0x8000_0000, hi=0.
//  alu_sel=1 only in RUN; otherwise alu_a=alu_b=0, alu_control=010 (combinational from state).
//  flush in RUN/FIX: IDLE next edge, hi/lo/div_by_zero unchanged, no done. flush+start in IDLE: flush wins.
//  flush in the FIX cycle: FIX discarded, no hi/lo write.
//  rst_n low at any time: immediate reset values, op lost.
// CONFIGURATION
//  MDU_EARLY_OUT_EN defined: MULT/MULTU RUN step checks residue acc_lo[31-cnt:0]; if zero,
//   shifts {acc_hi,acc_lo} right by 32-cnt in that cycle (no ALU add) and goes to FIX.
//   Multiplier 0 -> done cycle 3. Divide unaffected.
//  Undefined: fixed 32 RUN cycles for all ops; done always cycle 34 (div-by-zero cycle 2).
// TESTING
//  MULTU FFFF_FFFF*FFFF_FFFF -> hi=FFFF_FFFE lo=0000_0001, done cycle 34 (macro off), busy 1..33.
//  MULT -3*7 -> hi=FFFF_FFFF lo=FFFF_FFEB; MULT 0x8000_0000*0x8000_0000 -> hi=4000_0000 lo=0.
//  DIV -7/2 -> lo=FFFF_FFFD hi=FFFF_FFFF; DIVU 100/7 -> lo=0000_000E hi=0000_0002.
//  DIVU 0x1234/0 -> div_by_zero=1 hi=0000_1234 lo=FFFF_FFFF, done cycle 2; alu_sel never 1.
//  Flush in cycle 10 of MULTU -> busy=0 cycle 11, no done, hi/lo keep prior values.
//   rst_n low mid-RUN -> all outputs at reset values immediately.
//  MDU_EARLY_OUT_EN: MULTU 5*3 -> hi=0 lo=0000_000F, done cycle 5.
//   start pulsed while busy -> ignored, result of first op intact.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU sequencer that borrows the shared ALU and owns HI/LO.
// Optional MDU_EARLY_OUT_EN: multiply finishes early once the remaining multiplier bits are zero.
module mdu_sequencer #(
  parameter int WIDTH      = 32,
  parameter bit DONE_PULSE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result
);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;      // |multiplicand| or |divisor|
  logic [WIDTH-1:0] rs_q, rs_d;          // raw dividend for the div-by-zero HI value
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;        // operand signs differ
  logic             rem_neg_q, rem_neg_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             rs_neg, rt_neg, take, carry;
  logic [WIDTH-1:0] rs_abs, rt_abs, sh;
  logic [63:0]      prod, prod_neg;
`ifdef MDU_EARLY_OUT_EN
  logic [WIDTH-1:0] res_mask;
`endif

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opnd_d     = opnd_q;
    rs_d       = rs_q;
    is_div_d   = is_div_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    dbz_pend_d = dbz_pend_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    dbz_d      = dbz_q;
    done_d     = DONE_PULSE ? 1'b0 : done_q;
    alu_sel     = 1'b0;
    alu_a       = '0;
    alu_b       = '0;
    alu_control = ALU_ADD;

    rs_neg   = ~op[0] & rs_val[WIDTH-1];
    rt_neg   = ~op[0] & rt_val[WIDTH-1];
    rs_abs   = rs_neg ? (~rs_val + 1'b1) : rs_val;
    rt_abs   = rt_neg ? (~rt_val + 1'b1) : rt_val;
    sh       = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
    take     = 1'b0;
    carry    = 1'b0;
    prod     = {acc_hi_q, acc_lo_q};
    prod_neg = ~prod + 64'd1;
`ifdef MDU_EARLY_OUT_EN
    res_mask = {WIDTH{1'b1}} >> cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (flush) begin
          done_d = 1'b0;
        end else if (start) begin
          done_d     = 1'b0;
          is_div_d   = op[1];
          neg_d      = rs_neg ^ rt_neg;
          rem_neg_d  = rs_neg;
          rs_d       = rs_val;
          cnt_d      = '0;
          acc_hi_d   = '0;
          acc_lo_d   = op[1] ? rs_abs : rt_abs;
          opnd_d     = op[1] ? rt_abs : rs_abs;
          dbz_pend_d = op[1] && (rt_val == '0);
          state_d    = (op[1] && (rt_val == '0)) ? FIX : RUN;
        end
      end

      RUN: begin
        alu_sel = 1'b1;
        cnt_d   = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
        if (is_div_q) begin
          alu_a       = sh;
          alu_b       = opnd_q;
          alu_control = ALU_SUB;
          // The bit shifted out of acc_hi means sh really exceeds the divisor.
          take        = acc_hi_q[WIDTH-1] | ~(sh < opnd_q);
          acc_hi_d    = take ? alu_result : sh;
          acc_lo_d    = {acc_lo_q[WIDTH-2:0], take};
        end else begin
          alu_a    = acc_hi_q;
          alu_b    = acc_lo_q[0] ? opnd_q : '0;
          carry    = (alu_result < acc_hi_q);
          acc_hi_d = {carry, alu_result[WIDTH-1:1]};
          acc_lo_d = {alu_result[0], acc_lo_q[WIDTH-1:1]};
`ifdef MDU_EARLY_OUT_EN
          // No multiplier bits left: the remaining steps would only shift.
          if ((acc_lo_q & res_mask) == '0) begin
            {acc_hi_d, acc_lo_d} = prod >> (6'd32 - {1'b0, cnt_q});
            state_d = FIX;
          end
`endif
        end
        if (flush) state_d = IDLE;
      end

      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          dbz_d  = dbz_pend_q;
          if (dbz_pend_q) begin
            hi_d = rs_q;
            lo_d = '1;
          end else if (is_div_q) begin
            lo_d = neg_q     ? (~acc_lo_q + 1'b1) : acc_lo_q;
            hi_d = rem_neg_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
          end else begin
            {hi_d, lo_d} = neg_q ? prod_neg : prod;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_hi_q   <= '0;
      acc_lo_q   <= '0;
      opnd_q     <= '0;
      rs_q       <= '0;
      is_div_q   <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      dbz_pend_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      dbz_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_hi_q   <= acc_hi_d;
      acc_lo_q   <= acc_lo_d;
      opnd_q     <= opnd_d;
      rs_q       <= rs_d;
      is_div_q   <= is_div_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      dbz_pend_q <= dbz_pend_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      dbz_q      <= dbz_d;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed-vector bench for mdu_sequencer with a simple behavioural 32-bit ALU.
module tb_mdu_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] rs_val = '0, rt_val = '0;
  logic        flush = 1'b0;
  logic        busy, done, div_by_zero, alu_sel;
  logic [31:0] hi, lo, alu_a, alu_b, alu_result;
  logic [2:0]  alu_control;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  assign alu_result = (alu_control == 3'b110) ? (alu_a - alu_b) : (alu_a + alu_b);

  mdu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .flush(flush), .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Launch in cycle 0, then watch until done (bounded); cycle numbers count from the launch.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int done_cyc, output int busy_n, output bit sel_seen);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    done_cyc = -1; busy_n = 0; sel_seen = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy) busy_n++;
      if (alu_sel) sel_seen = 1'b1;
      if (done) begin
        done_cyc = c;
        break;
      end
    end
  endtask

  int  dc, bn, ndone;
  bit  ss;

  initial begin
    #2;
    chk("rst_flags", {busy, done, div_by_zero, alu_sel}, 4'b0000);
    chk("rst_hilo", {hi, lo}, 64'h0);
    chk("rst_alu", {alu_a, alu_b, 29'd0, alu_control}, {32'h0, 32'h0, 32'h2});
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, bn, ss);
    chk("multu_ff_hilo", {hi, lo}, {32'hFFFF_FFFE, 32'h0000_0001});
    chk("multu_ff_done_cyc", dc, 34);
    chk("multu_ff_busy_n", bn, 33);
    chk("multu_ff_dbz", div_by_zero, 1'b0);
    @(negedge clk);
    chk("done_pulse_drop", done, 1'b0);

    do_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, dc, bn, ss);
    chk("mult_m3x7", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});

    do_op(2'b00, 32'h8000_0000, 32'h8000_0000, dc, bn, ss);
    chk("mult_min_sq", {hi, lo}, {32'h4000_0000, 32'h0});

    do_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, dc, bn, ss);
    chk("div_m7_2", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    chk("div_m7_2_cyc", dc, 34);
    chk("div_m7_2_sel", ss, 1'b1);

    do_op(2'b11, 32'd100, 32'd7, dc, bn, ss);
    chk("divu_100_7", {hi, lo}, {32'h0000_0002, 32'h0000_000E});

    do_op(2'b11, 32'h0000_1234, 32'h0, dc, bn, ss);
    chk("dbz_hilo", {hi, lo}, {32'h0000_1234, 32'hFFFF_FFFF});
    chk("dbz_flag", div_by_zero, 1'b1);
    chk("dbz_done_cyc", dc, 2);
    chk("dbz_no_alu", ss, 1'b0);

    // Flush mid-RUN: prior HI/LO and div_by_zero must survive.
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy_c11", busy, 1'b0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("flush_no_done", ndone, 0);
    chk("flush_hilo_kept", {hi, lo}, {32'h0000_1234, 32'hFFFF_FFFF});
    chk("flush_dbz_kept", div_by_zero, 1'b1);

    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, dc, bn, ss);
    chk("div_ovf", {hi, lo}, {32'h0, 32'h8000_0000});
    chk("div_ovf_dbz", div_by_zero, 1'b0);

    // Start pulsed while busy (a div-by-zero op) must be ignored.
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_val = 32'd5; rt_val = 32'd3;
    dc = -1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 2) begin
        start = 1'b1; op = 2'b11; rs_val = 32'd9; rt_val = 32'd0;
      end
      if (done) begin
        dc = c;
        break;
      end
    end
    start = 1'b0;
    chk("multu_5x3", {hi, lo}, {32'h0, 32'h0000_000F});
`ifdef MDU_EARLY_OUT_EN
    chk("multu_5x3_cyc", dc, 5);
`else
    chk("multu_5x3_cyc", dc, 34);
`endif
    chk("busy_start_ignored", div_by_zero, 1'b0);
    for (int c = 0; c < 3; c++) @(negedge clk);
    chk("no_second_op", {busy, hi}, {1'b0, 32'h0});

    // Asynchronous reset mid-RUN.
    @(negedge clk);
    start = 1'b1; op = 2'b01; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1 rst_n = 1'b0;
    #1;
    chk("arst_flags", {busy, done, div_by_zero, alu_sel}, 4'b0000);
    chk("arst_hilo", {hi, lo}, 64'h0);
    chk("arst_alu", {alu_a, alu_b, 29'd0, alu_control}, {32'h0, 32'h0, 32'h2});
    @(negedge clk);
    rst_n = 1'b1;

    do_op(2'b11, 32'd100, 32'd7, dc, bn, ss);
    chk("post_rst_divu", {hi, lo}, {32'h0000_0002, 32'h0000_000E});

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
